// File: rtl/nibble_serializer_pkg.sv
// Shared types and constants for the byte-to-nibble serializer.
package nibble_serializer_pkg;

   localparam int NIBBLE_NBITS = 4;
   localparam int BYTE_NBITS   = 8;

   // Serializer control state: what the byte register currently holds.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,   // no byte held
      FIRST  = 2'd1,   // byte held, first nibble on the output
      SECOND = 2'd2    // byte held, second nibble on the output
   } state_t;

   // Pick one half of a split byte.
   function automatic logic [NIBBLE_NBITS-1:0] select_nibble(
      input logic [NIBBLE_NBITS-1:0] lo,
      input logic [NIBBLE_NBITS-1:0] hi,
      input logic                    take_lo
   );
      logic [NIBBLE_NBITS-1:0] nib;
      if (take_lo) begin
         nib = lo;
      end else begin
         nib = hi;
      end
      return nib;
   endfunction

endpackage

// File: rtl/nibble_serializer_if.sv
// Byte-in / nibble-out handshake bundle for the serializer.
// slave is the serializer side, master is the producer/consumer side.
interface nibble_serializer_if #(
   parameter int COUNT_NBITS = 8
);
   import nibble_serializer_pkg::*;

   logic                    in_val;
   logic                    in_rdy;
   logic [BYTE_NBITS-1:0]   in_msg;
   logic                    out_val;
   logic                    out_rdy;
   logic [NIBBLE_NBITS-1:0] out_msg;
   logic                    out_last;
   logic [COUNT_NBITS-1:0]  count;

   modport slave (
      input  in_val,
      input  in_msg,
      input  out_rdy,
      output in_rdy,
      output out_val,
      output out_msg,
      output out_last,
      output count
   );

   modport master (
      output in_val,
      output in_msg,
      output out_rdy,
      input  in_rdy,
      input  out_val,
      input  out_msg,
      input  out_last,
      input  count
   );

endinterface

// File: rtl/nibble_serializer_split.sv
// Purely combinational split of a byte into its low and high nibbles.
module nibble_split
   import nibble_serializer_pkg::*;
(
   input  logic [BYTE_NBITS-1:0]   in_,
   output logic [NIBBLE_NBITS-1:0] lo,
   output logic [NIBBLE_NBITS-1:0] hi
);

   assign lo = in_[NIBBLE_NBITS-1:0];
   assign hi = in_[BYTE_NBITS-1:NIBBLE_NBITS];

endmodule

// File: rtl/nibble_serializer.sv
// Latches one byte at a time and emits it as two nibbles (order set by
// LO_FIRST), counting bytes whose second nibble has been accepted.
// The only combinational input-to-output path is out_rdy -> in_rdy, which
// lets a new byte be taken on the same edge the second nibble leaves.
module nibble_serializer
   import nibble_serializer_pkg::*;
#(
   parameter bit LO_FIRST    = 1'b1,
   parameter int COUNT_NBITS = 8
)(
   input logic                clk,
   input logic                reset,
   nibble_serializer_if.slave bus
);

   state_t                  state_r;
   state_t                  state_nxt_s;
   logic [BYTE_NBITS-1:0]   byte_r;
   logic [COUNT_NBITS-1:0]  count_r;

   logic [NIBBLE_NBITS-1:0] lo_s;
   logic [NIBBLE_NBITS-1:0] hi_s;

   logic                    in_rdy_s;
   logic                    out_val_s;
   logic                    out_last_s;
   logic                    take_lo_s;
   logic [NIBBLE_NBITS-1:0] out_msg_s;
   logic                    in_fire_s;
   logic                    out_fire_s;

   nibble_split u_split (
      .in_ (byte_r),
      .lo  (lo_s),
      .hi  (hi_s)
   );

   assign in_fire_s  = bus.in_val & in_rdy_s;
   assign out_fire_s = out_val_s & bus.out_rdy;

   // State register; reset drops any held byte immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state: accept in IDLE, advance on each nibble accepted,
   // and chain straight into the next byte from SECOND when one is offered.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (in_fire_s) begin
               state_nxt_s = FIRST;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         FIRST: begin
            if (out_fire_s) begin
               state_nxt_s = SECOND;
            end else begin
               state_nxt_s = FIRST;
            end
         end
         SECOND: begin
            if (out_fire_s && in_fire_s) begin
               state_nxt_s = FIRST;
            end else if (out_fire_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = SECOND;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Output decode: handshakes and which nibble of the held byte to show.
   // in_rdy is forced low while reset is asserted even though the state
   // already reads IDLE.
   always_comb begin
      in_rdy_s   = 1'b0;
      out_val_s  = 1'b0;
      out_last_s = 1'b0;
      take_lo_s  = LO_FIRST;
      case (state_r)
         IDLE: begin
            in_rdy_s  = ~reset;
            take_lo_s = LO_FIRST;
         end
         FIRST: begin
            out_val_s = 1'b1;
            take_lo_s = LO_FIRST;
         end
         SECOND: begin
            in_rdy_s   = bus.out_rdy & ~reset;
            out_val_s  = 1'b1;
            out_last_s = 1'b1;
            take_lo_s  = ~LO_FIRST;
         end
         default: begin
            in_rdy_s   = 1'b0;
            out_val_s  = 1'b0;
            out_last_s = 1'b0;
            take_lo_s  = LO_FIRST;
         end
      endcase
      out_msg_s = select_nibble(lo_s, hi_s, take_lo_s);
   end

   // Byte register: loads only on an accepted input byte.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         byte_r <= {BYTE_NBITS{1'b0}};
      end else if (in_fire_s) begin
         byte_r <= bus.in_msg;
      end else begin
         byte_r <= byte_r;
      end
   end

   // Completed-byte counter: bumps when the second nibble is accepted, wraps freely.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_r <= {COUNT_NBITS{1'b0}};
      end else if ((state_r == SECOND) && out_fire_s) begin
         count_r <= count_r + {{(COUNT_NBITS-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

   assign bus.in_rdy   = in_rdy_s;
   assign bus.out_val  = out_val_s;
   assign bus.out_last = out_last_s;
   assign bus.out_msg  = out_msg_s;
   assign bus.count    = count_r;

endmodule

// File: tb/tb_nibble_serializer.sv
// Directed bench for nibble_serializer: three instances (lo-first/8-bit count,
// hi-first/8-bit count, lo-first/2-bit count) sharing clock and reset.
module tb_nibble_serializer;

   logic clk;
   logic reset;

   int checks = 0;
   int errors = 0;

   nibble_serializer_if #(.COUNT_NBITS(8)) b_lo();
   nibble_serializer_if #(.COUNT_NBITS(8)) b_hi();
   nibble_serializer_if #(.COUNT_NBITS(2)) b_w2();

   nibble_serializer #(.LO_FIRST(1'b1), .COUNT_NBITS(8)) u_lo (
      .clk(clk), .reset(reset), .bus(b_lo)
   );
   nibble_serializer #(.LO_FIRST(1'b0), .COUNT_NBITS(8)) u_hi (
      .clk(clk), .reset(reset), .bus(b_hi)
   );
   nibble_serializer #(.LO_FIRST(1'b1), .COUNT_NBITS(2)) u_w2 (
      .clk(clk), .reset(reset), .bus(b_w2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge; inputs are then changed 1 time unit after it, and
   // outputs are sampled a further unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin : stim
      logic [1:0] wrap_exp [5];
      wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
      wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;

      reset = 1'b1;
      b_lo.in_val = 1'b1; b_lo.in_msg = 8'hFF; b_lo.out_rdy = 1'b1;
      b_hi.in_val = 1'b0; b_hi.in_msg = 8'h00; b_hi.out_rdy = 1'b1;
      b_w2.in_val = 1'b0; b_w2.in_msg = 8'h00; b_w2.out_rdy = 1'b1;

      // Reset held for two cycles with in_val asserted.
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_in_rdy",  {7'd0, b_lo.in_rdy},  8'h00);
         chk("rst_out_val", {7'd0, b_lo.out_val}, 8'h00);
         chk("rst_out_msg", {4'd0, b_lo.out_msg}, 8'h00);
         chk("rst_count",   b_lo.count,           8'h00);
      end
      reset = 1'b0;
      b_lo.in_val = 1'b0;
      settle();
      chk("idle_in_rdy",  {7'd0, b_lo.in_rdy},  8'h01);
      chk("idle_out_val", {7'd0, b_lo.out_val}, 8'h00);

      // Single byte 0xA5, lo first.
      b_lo.in_val = 1'b1; b_lo.in_msg = 8'hA5;
      settle();
      chk("a5_accept_rdy", {7'd0, b_lo.in_rdy}, 8'h01);
      tick();
      b_lo.in_val = 1'b0;
      settle();
      chk("a5_first_val",  {7'd0, b_lo.out_val},  8'h01);
      chk("a5_first_msg",  {4'd0, b_lo.out_msg},  8'h05);
      chk("a5_first_last", {7'd0, b_lo.out_last}, 8'h00);
      chk("a5_first_rdy",  {7'd0, b_lo.in_rdy},   8'h00);
      tick();
      settle();
      chk("a5_second_msg",  {4'd0, b_lo.out_msg},  8'h0A);
      chk("a5_second_last", {7'd0, b_lo.out_last}, 8'h01);
      chk("a5_second_rdy",  {7'd0, b_lo.in_rdy},   8'h01);
      tick();
      settle();
      chk("a5_done_val",   {7'd0, b_lo.out_val}, 8'h00);
      chk("a5_done_count", b_lo.count,           8'h01);

      // Back-to-back 0x23, 0x45, 0x67 with no idle bubble.
      b_lo.in_val = 1'b1; b_lo.in_msg = 8'h23;
      settle();
      tick();
      b_lo.in_msg = 8'h45;
      settle();
      chk("b2b_n0", {4'd0, b_lo.out_msg}, 8'h03);
      chk("b2b_n0_rdy", {7'd0, b_lo.in_rdy}, 8'h00);
      tick();
      settle();
      chk("b2b_n1", {4'd0, b_lo.out_msg}, 8'h02);
      chk("b2b_n1_last", {7'd0, b_lo.out_last}, 8'h01);
      chk("b2b_n1_rdy", {7'd0, b_lo.in_rdy}, 8'h01);
      tick();
      b_lo.in_msg = 8'h67;
      settle();
      chk("b2b_n2", {4'd0, b_lo.out_msg}, 8'h05);
      chk("b2b_n2_val", {7'd0, b_lo.out_val}, 8'h01);
      chk("b2b_n2_rdy", {7'd0, b_lo.in_rdy}, 8'h00);
      tick();
      settle();
      chk("b2b_n3", {4'd0, b_lo.out_msg}, 8'h04);
      chk("b2b_n3_rdy", {7'd0, b_lo.in_rdy}, 8'h01);
      tick();
      b_lo.in_val = 1'b0;
      settle();
      chk("b2b_n4", {4'd0, b_lo.out_msg}, 8'h07);
      chk("b2b_n4_val", {7'd0, b_lo.out_val}, 8'h01);
      tick();
      settle();
      chk("b2b_n5", {4'd0, b_lo.out_msg}, 8'h06);
      chk("b2b_n5_last", {7'd0, b_lo.out_last}, 8'h01);
      tick();
      settle();
      // One byte from the single-byte step plus three here.
      chk("b2b_count", b_lo.count, 8'h04);
      chk("b2b_idle_val", {7'd0, b_lo.out_val}, 8'h00);

      // Backpressure on 0xCD: first nibble held three cycles, then second held once.
      b_lo.in_val = 1'b1; b_lo.in_msg = 8'hCD; b_lo.out_rdy = 1'b0;
      settle();
      chk("bp_idle_rdy", {7'd0, b_lo.in_rdy}, 8'h01);
      tick();
      b_lo.in_val = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("bp_hold_msg", {4'd0, b_lo.out_msg}, 8'h0D);
         chk("bp_hold_val", {7'd0, b_lo.out_val}, 8'h01);
         chk("bp_hold_rdy", {7'd0, b_lo.in_rdy},  8'h00);
         chk("bp_hold_cnt", b_lo.count,           8'h04);
         tick();
      end
      b_lo.out_rdy = 1'b1;
      settle();
      chk("bp_rel_msg", {4'd0, b_lo.out_msg}, 8'h0D);
      tick();
      b_lo.out_rdy = 1'b0;
      settle();
      chk("bp_sec_hold_msg", {4'd0, b_lo.out_msg}, 8'h0C);
      chk("bp_sec_hold_rdy", {7'd0, b_lo.in_rdy},  8'h00);
      tick();
      b_lo.out_rdy = 1'b1;
      settle();
      chk("bp_sec_msg", {4'd0, b_lo.out_msg}, 8'h0C);
      chk("bp_sec_cnt", b_lo.count,           8'h04);
      chk("bp_sec_rdy", {7'd0, b_lo.in_rdy},  8'h01);
      tick();
      settle();
      chk("bp_count", b_lo.count, 8'h05);

      // Hi-first instance: 0x89, 0xEF back-to-back -> 8,9,E,F.
      b_hi.in_val = 1'b1; b_hi.in_msg = 8'h89;
      settle();
      tick();
      b_hi.in_msg = 8'hEF;
      settle();
      chk("hi_n0", {4'd0, b_hi.out_msg}, 8'h08);
      chk("hi_n0_last", {7'd0, b_hi.out_last}, 8'h00);
      tick();
      settle();
      chk("hi_n1", {4'd0, b_hi.out_msg}, 8'h09);
      chk("hi_n1_last", {7'd0, b_hi.out_last}, 8'h01);
      tick();
      b_hi.in_val = 1'b0;
      settle();
      chk("hi_n2", {4'd0, b_hi.out_msg}, 8'h0E);
      chk("hi_n2_last", {7'd0, b_hi.out_last}, 8'h00);
      tick();
      settle();
      chk("hi_n3", {4'd0, b_hi.out_msg}, 8'h0F);
      chk("hi_n3_last", {7'd0, b_hi.out_last}, 8'h01);
      tick();
      settle();
      chk("hi_count", b_hi.count, 8'h02);

      // Two-bit counter wraps after four bytes.
      for (int i = 0; i < 5; i++) begin
         b_w2.in_val = 1'b1; b_w2.in_msg = 8'h10 + 8'(i);
         settle();
         tick();
         b_w2.in_val = 1'b0;
         tick();
         tick();
         settle();
         chk("wrap_count", {6'd0, b_w2.count}, {6'd0, wrap_exp[i]});
      end

      // Reset in SECOND: output drops without a clock edge, byte and count lost.
      b_lo.in_val = 1'b1; b_lo.in_msg = 8'h3C;
      settle();
      tick();
      b_lo.in_val = 1'b0;
      tick();
      settle();
      chk("mr_pre_last", {7'd0, b_lo.out_last}, 8'h01);
      chk("mr_pre_msg",  {4'd0, b_lo.out_msg},  8'h03);
      reset = 1'b1;
      settle();
      chk("mr_out_val", {7'd0, b_lo.out_val}, 8'h00);
      chk("mr_out_msg", {4'd0, b_lo.out_msg}, 8'h00);
      chk("mr_in_rdy",  {7'd0, b_lo.in_rdy},  8'h00);
      chk("mr_count",   b_lo.count,           8'h00);
      chk("mr_w2_count", {6'd0, b_w2.count},  8'h00);
      tick();
      reset = 1'b0;
      settle();
      chk("mr_after_val", {7'd0, b_lo.out_val}, 8'h00);
      chk("mr_after_rdy", {7'd0, b_lo.in_rdy},  8'h01);
      tick();
      settle();
      chk("mr_no_replay", {7'd0, b_lo.out_val}, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/nibble_serializer.md
Name: nibble_serializer

Overview:
Sequences the 8-bit lo/hi nibble split datapath onto a narrow 4-bit stream. Accepts bytes over a val/rdy input interface, latches each byte, and emits its two nibbles over two output handshakes, in a configurable order. Sits between a byte-wide producer and a nibble-wide link or consumer. Sustains one byte per two cycles under continuous backpressure-free operation.

Parameters:
LO_FIRST, 1, 1 = emit lo nibble (bits 3:0) first, then hi (bits 7:4); 0 = hi first, then lo
COUNT_NBITS, 8, width of completed-byte counter

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
in_val  input  1  input byte valid
in_rdy  output  1  serializer can accept a byte this cycle
in_msg  input  8  input byte
out_val  output  1  output nibble valid
out_rdy  input  1  consumer accepts nibble this cycle
out_msg  output  4  output nibble
out_last  output  1  high when out_msg is the second nibble of the byte
count  output  COUNT_NBITS  number of fully transmitted bytes, modulo 2^COUNT_NBITS

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset, applied immediately and regardless of clock:
  - state = IDLE; byte register = 0x00; count = 0.
  - Outputs during reset: out_val = 0, out_last = 0, out_msg = 0, in_rdy = 0.
- Reset mid-operation discards the latched byte and any partially sent nibble. There is no replay.
- States:
  - IDLE: no byte held.
  - FIRST: byte held, first nibble presented.
  - SECOND: byte held, second nibble presented.
- Input handshake (in_fire = in_val & in_rdy):
  - in_rdy = 1 in IDLE.
  - in_rdy = out_rdy in SECOND.
  - in_rdy = 0 in FIRST and while reset.
- Output handshake (out_fire = out_val & out_rdy):
  - out_val = 1 in FIRST and SECOND, 0 in IDLE.
  - out_last = 1 only in SECOND.
  - out_msg is combinational from the byte register through the split datapath.
  - FIRST presents lo if LO_FIRST=1, hi otherwise. SECOND presents the other nibble.
  - In IDLE, out_msg = first nibble of the stale register. Consumers ignore it while out_val = 0.
- Transitions:
  - IDLE: in_fire -> latch in_msg, go to FIRST. Otherwise stay.
  - FIRST: out_fire -> SECOND. Otherwise hold; register and out_msg stable.
  - SECOND with out_fire and in_fire: latch new byte, go to FIRST. This is back-to-back, with no IDLE bubble.
  - SECOND with out_fire only: go to IDLE.
  - SECOND without out_fire: hold.
- Latency: a byte accepted at edge t has its first nibble valid in the cycle after t. The second nibble follows one cycle after the first fires.
- Throughput: 2 cycles per byte when out_rdy is held 1 and in_val is held 1.
- count increments by 1 on each out_fire in SECOND. It wraps from 2^COUNT_NBITS-1 to 0. It never changes on any other event.
- No combinational path from in_val to out_val. The only combinational path is out_rdy -> in_rdy.
- out_val never drops without out_fire. out_msg never changes while out_val=1 && out_rdy=0.

Decomposition:
- Shared package nibble_serializer_pkg:
  - state enum typedef (IDLE, FIRST, SECOND), 2-bit encoding.
  - NIBBLE_NBITS = 4 and BYTE_NBITS = 8 constants.
- One sub-module: nibble_split. It is purely combinational: 8-bit in_ -> 4-bit lo (bits 3:0) and hi (bits 7:4). It is instantiated once on the byte register, and out_msg is muxed from lo/hi by state and LO_FIRST.
- Everything else (FSM, register, counter) lives in nibble_serializer.

Test Plan:
- Reset then idle, LO_FIRST=1: reset high for 2 cycles with in_val=1 -> in_rdy=0, out_val=0, out_msg=0, count=0 throughout. After release: in_rdy=1, out_val=0.
- Single byte, LO_FIRST=1, out_rdy=1: send 0xA5 -> next cycle out_msg=0x5, out_last=0. Following cycle out_msg=0xA, out_last=1. Then IDLE, with count=1.
- Back-to-back, out_rdy=1, in_val=1: stream 0x23, 0x45, 0x67 -> nibbles 3,2,5,4,7,6 on consecutive cycles with no bubbles. in_rdy high only in IDLE/SECOND cycles. count=3.
- Backpressure: send 0xCD with out_rdy=0 for 3 cycles -> out_msg holds 0xD, out_val=1, in_rdy=0. Then out_rdy=1 -> 0xD then 0xC emitted, count increments once.
- LO_FIRST=0 instance: send 0x89, 0xEF -> nibbles 8,9,E,F with out_last on 9 and F.
- Mid-operation reset and wrap: reset asserted while in SECOND -> out_val drops immediately, byte lost, count=0. With COUNT_NBITS=2, send 5 bytes -> count sequence 1,2,3,0,1.
